fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - Instruction-fetch sequencer directly upstream of memory_datapath: owns the PC, drives it onto the
//   memory address path (MemDst=3'b000, MemWrite=0), and captures mem_out into the instruction register.
// - Hands the instruction to control through a valid/ready handshake.
// - Supplies pc_plus2 for the RA link, and accepts branch/jump redirects.
// PARAMETERS
// - RESET_PC   16'h0000  PC value loaded on reset
// - PC_STEP    2         byte increment per instruction (16-bit words)
// PORTS
// - clock           in   1   single system clock, rising edge
// - reset           in   1   synchronous, active-low reset
// - stall           in   1   memory port is claimed by a load/store; freeze the fetch FSM
// - mem_out         in   16  read data from memory_datapath; valid the cycle after the address is presented
// - redirect_valid  in   1   branch/jump taken this cycle
// - redirect_pc     in   16  target PC for the redirect
// - ir_ready        in   1   control consumes ir this cycle
// - pc_out          out  16  current fetch PC; drives memory_datapath pc
// - fetch_active    out  1   fetch owns the memory port; control must select MemDst=000 and MemWrite=0
// - ir              out  16  instruction register
// - ir_valid        out  1   ir holds an unconsumed instruction
// - ir_pc           out  16  PC of the instruction currently in ir
// - pc_plus2        out  16  ir_pc + PC_STEP; the return address for jal-type instructions
// - misalign_err    out  1   odd redirect target rejected (only with FETCH_ALIGN_CHECK_EN)
// BEHAVIOUR
// - Reset (reset==0 at a posedge), including mid-operation:
//   - state=ADDR, pc_out=RESET_PC.
//   - ir=0, ir_pc=0, pc_plus2=PC_STEP, ir_valid=0, fetch_active=0, misalign_err=0.
//   - Any in-flight fetch is discarded.
// - FSM states: ADDR, CAPT, HOLD.
// - ADDR: fetch_active=1 while stall==0. A posedge with stall==0 moves to CAPT. Stall holds ADDR.
// - CAPT: mem_out for pc_out is valid.
//   - On a posedge with stall==0: ir<=mem_out, ir_pc<=pc_out, pc_out<=pc_out+PC_STEP, ir_valid<=1, go to HOLD.
//   - stall holds CAPT and keeps fetch_active=0. Re-entry to CAPT after a stall forces one ADDR cycle first,
//     because stalled memory traffic overwrote mem_out.
// - HOLD: ir_valid=1 and fetch_active=0. A posedge with ir_ready==1 gives ir_valid<=0 and moves to ADDR.
//   - Fetch latency is therefore 2 cycles from ADDR to ir_valid, with no overlap between fetches.
// - Redirect has priority over every other event in any state, including a simultaneous stall or ir_ready:
//   - pc_out<=redirect_pc, ir_valid<=0, go to ADDR.
//   - Any in-flight capture is squashed: ir is not updated.
// - Arithmetic: 16-bit modulo. 16'hFFFE + 2 wraps to 16'h0000 with no flag. pc_plus2 uses the same wrap.
// - fetch_active is combinational from the state and stall. All other outputs are registered.
// - ir holds its value when ir_valid==0, which keeps it debug-visible.
// CONFIGURATION
// - Macro FETCH_ALIGN_CHECK_EN.
// - Defined:
//   - A redirect with redirect_pc[0]==1 is rejected: pc_out is unchanged and the FSM still goes to ADDR
//     with ir_valid<=0.
//   - misalign_err<=1 and stays set until reset.
// - Undefined:
//   - redirect_pc[0] is forced to 0 on load.
//   - misalign_err is tied to 0.
// STRUCTURE
// - Shared package cpu_pkg holds:
//   - localparams FS_ADDR=2'd0, FS_CAPT=2'd1, FS_HOLD=2'd2
//   - MEMDST_PC=3'b000
//   - WORD_W=16
//   - PC_STEP default
// - One sub-module, pc_reg: a 16-bit PC register with load, increment and wrap. The FSM and IR stay inline.
// TESTING
// - Reset release with RESET_PC=0 and mem_out=16'h1234 at addr 0, ir_ready held 1:
//   - ir_valid rises 2 cycles after release.
//   - ir=16'h1234, ir_pc=0, pc_plus2=2, pc_out=2.
// - ir_ready=0 for 5 cycles in HOLD:
//   - ir, ir_valid and pc_out remain stable.
//   - fetch_active=0 throughout.
//   - Raising ir_ready gives ir_valid=0 the next cycle, then a fetch of addr 2.
// - stall=1 for 3 cycles asserted in CAPT:
//   - No ir update and fetch_active=0.
//   - After release: one ADDR cycle, then ir=mem[pc], with correct data and not the stale word.
// - redirect_valid=1 and redirect_pc=16'h0040 in the same cycle as the CAPT posedge:
//   - The old word is not latched.
//   - Next ir=mem[0x40], ir_pc=0x40.
// - PC at 16'hFFFE:
//   - Fetch yields ir_pc=16'hFFFE, pc_plus2=16'h0000, pc_out=16'h0000.
// - redirect_pc=16'h0043:
//   - With the macro: pc_out is unchanged and misalign_err=1 until reset.
//   - Without the macro: pc_out=16'h0042 and misalign_err=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and its PC register.
//   - FS_ADDR/FS_CAPT/FS_HOLD : fetch FSM encodings
//   - MEMDST_PC               : memory-destination select that control uses while fetch owns the port
//   - WORD_W                  : datapath / instruction width
//   - PC_STEP_DEFAULT         : byte increment per 16-bit instruction
//   - pc_add()                : modulo-2^WORD_W PC adder, used for the increment and the link address
package cpu_pkg;

   localparam int WORD_W = 16;

   localparam logic [1:0] FS_ADDR = 2'd0;
   localparam logic [1:0] FS_CAPT = 2'd1;
   localparam logic [1:0] FS_HOLD = 2'd2;

   localparam logic [2:0] MEMDST_PC = 3'b000;

   localparam logic [WORD_W-1:0] PC_STEP_DEFAULT = 16'd2;

   typedef enum logic [1:0] {
      ST_ADDR = FS_ADDR,
      ST_CAPT = FS_CAPT,
      ST_HOLD = FS_HOLD
   } fetch_state_e;

   // Wraps silently: 16'hFFFE + 2 gives 16'h0000.
   function automatic logic [WORD_W-1:0] pc_add(input logic [WORD_W-1:0] pc,
                                                 input logic [WORD_W-1:0] step);
      return pc + step;
   endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter with load, increment and 16-bit wrap.
// Ports:
//   clk_i      in   clock, rising edge
//   rst_ni     in   synchronous active-low reset, loads RESET_PC
//   load_i     in   load load_pc_i (takes priority over inc_i)
//   load_pc_i  in   value to load
//   inc_i      in   advance by PC_STEP
//   pc_o       out  current PC
//   pc_inc_o   out  pc_o + PC_STEP (combinational, wraps)
import cpu_pkg::*;

module pc_reg #(
   parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
   parameter logic [WORD_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [WORD_W-1:0] load_pc_i,
   input  logic              inc_i,
   output logic [WORD_W-1:0] pc_o,
   output logic [WORD_W-1:0] pc_inc_o
);

   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] pc_d;
   logic [WORD_W-1:0] pc_inc_s;

   // Next-PC selection: load beats increment, otherwise hold.
   always_comb begin
      pc_inc_s = pc_add(pc_q, PC_STEP);
      pc_d     = pc_q;
      if (load_i) begin
         pc_d = load_pc_i;
      end else if (inc_i) begin
         pc_d = pc_inc_s;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC storage.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o     = pc_q;
   assign pc_inc_o = pc_inc_s;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch sequencer in front of memory_datapath.
// Presents pc_out on the memory address path (ADDR), captures mem_out one
// cycle later (CAPT) and holds it for control (HOLD) until ir_ready.
// Redirects override everything and squash any pending capture.
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   synchronous active-low reset
//   stall           in   memory port claimed by a load/store
//   mem_out         in   read data, valid the cycle after the address
//   redirect_valid  in   branch/jump taken
//   redirect_pc     in   redirect target
//   ir_ready        in   control consumes ir
//   pc_out          out  current fetch PC
//   fetch_active    out  fetch owns the memory port (combinational)
//   ir              out  instruction register
//   ir_valid        out  ir holds an unconsumed instruction
//   ir_pc           out  PC of the instruction in ir
//   pc_plus2        out  ir_pc + PC_STEP (link address)
//   misalign_err    out  sticky odd-redirect flag
// Build option: FETCH_ALIGN_CHECK_EN rejects odd redirect targets and sets
// misalign_err; without it bit 0 of the target is cleared and misalign_err is 0.
import cpu_pkg::*;

module fetch_stage #(
   parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
   parameter logic [WORD_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic [WORD_W-1:0] mem_out,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_pc,
   input  logic              ir_ready,
   output logic [WORD_W-1:0] pc_out,
   output logic              fetch_active,
   output logic [WORD_W-1:0] ir,
   output logic              ir_valid,
   output logic [WORD_W-1:0] ir_pc,
   output logic [WORD_W-1:0] pc_plus2,
   output logic              misalign_err
);

   fetch_state_e      state_q, state_d;
   // Set when a stall hit CAPT: mem_out was overwritten, so the address must be re-presented.
   logic              stalled_q, stalled_d;
   logic [WORD_W-1:0] ir_q, ir_d;
   logic [WORD_W-1:0] ir_pc_q, ir_pc_d;
   logic [WORD_W-1:0] pc_plus2_q, pc_plus2_d;
   logic              ir_valid_q, ir_valid_d;

   logic              pc_load_s;
   logic [WORD_W-1:0] pc_load_val_s;
   logic              pc_inc_en_s;
   logic [WORD_W-1:0] pc_s;
   logic [WORD_W-1:0] pc_inc_s;

`ifdef FETCH_ALIGN_CHECK_EN
   logic              misalign_q, misalign_d;
`else
   logic              unused_s;
   assign unused_s = redirect_pc[0];
`endif

   pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk_i     (clock),
      .rst_ni    (reset),
      .load_i    (pc_load_s),
      .load_pc_i (pc_load_val_s),
      .inc_i     (pc_inc_en_s),
      .pc_o      (pc_s),
      .pc_inc_o  (pc_inc_s)
   );

   // Fetch FSM next-state, IR capture and PC control.
   always_comb begin
      state_d       = state_q;
      stalled_d     = stalled_q;
      ir_d          = ir_q;
      ir_pc_d       = ir_pc_q;
      pc_plus2_d    = pc_plus2_q;
      ir_valid_d    = ir_valid_q;
      pc_load_s     = 1'b0;
      pc_load_val_s = redirect_pc;
      pc_inc_en_s   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d    = misalign_q;
`endif

      if (redirect_valid) begin
         // Redirect wins over stall/ir_ready and squashes any pending capture.
         state_d    = ST_ADDR;
         stalled_d  = 1'b0;
         ir_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[0]) begin
            misalign_d = 1'b1;
         end else begin
            pc_load_s     = 1'b1;
            pc_load_val_s = redirect_pc;
         end
`else
         pc_load_s     = 1'b1;
         pc_load_val_s = {redirect_pc[WORD_W-1:1], 1'b0};
`endif
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (!stall) begin
                  state_d = ST_CAPT;
               end else begin
                  state_d = ST_ADDR;
               end
            end
            ST_CAPT: begin
               if (stall) begin
                  stalled_d = 1'b1;
               end else if (stalled_q) begin
                  stalled_d = 1'b0;
                  state_d   = ST_ADDR;
               end else begin
                  ir_d        = mem_out;
                  ir_pc_d     = pc_s;
                  pc_plus2_d  = pc_inc_s;
                  pc_inc_en_s = 1'b1;
                  ir_valid_d  = 1'b1;
                  state_d     = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (ir_ready) begin
                  ir_valid_d = 1'b0;
                  state_d    = ST_ADDR;
               end else begin
                  state_d    = ST_HOLD;
               end
            end
            default: begin
               state_d    = ST_ADDR;
               stalled_d  = 1'b0;
               ir_valid_d = 1'b0;
            end
         endcase
      end
   end

   // FSM and instruction-register state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_ADDR;
         stalled_q  <= 1'b0;
         ir_q       <= 16'h0000;
         ir_pc_q    <= 16'h0000;
         pc_plus2_q <= PC_STEP;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         stalled_q  <= stalled_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         pc_plus2_q <= pc_plus2_d;
         ir_valid_q <= ir_valid_d;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // Sticky misaligned-redirect flag, cleared only by reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
   assign misalign_err = misalign_q;
`else
   assign misalign_err = 1'b0;
`endif

   // Gated by reset so the port is not claimed while the block is held in reset.
   assign fetch_active = reset && (state_q == ST_ADDR) && !stall;

   assign pc_out   = pc_s;
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign ir_pc    = ir_pc_q;
   assign pc_plus2 = pc_plus2_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a transaction-level
// reference model and a synchronous-read memory stand-in.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic [15:0] mem_out;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        ir_ready;
   logic [15:0] pc_out;
   logic        fetch_active;
   logic [15:0] ir;
   logic        ir_valid;
   logic [15:0] ir_pc;
   logic [15:0] pc_plus2;
   logic        misalign_err;

   always #5 clock = ~clock;

   fetch_stage #(
      .RESET_PC (16'h0000),
      .PC_STEP  (16'd2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .stall          (stall),
      .mem_out        (mem_out),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ir_ready       (ir_ready),
      .pc_out         (pc_out),
      .fetch_active   (fetch_active),
      .ir             (ir),
      .ir_valid       (ir_valid),
      .ir_pc          (ir_pc),
      .pc_plus2       (pc_plus2),
      .misalign_err   (misalign_err)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: architectural values plus "address presented cleanly last cycle"
   // (m_ok) and "one dead cycle owed after a stall spoiled a pending capture" (m_burn).
   logic [15:0] m_pc = 16'h0000, m_ir = 16'h0000, m_irpc = 16'h0000, m_p2 = 16'h0002;
   logic        m_v = 1'b0, m_mis = 1'b0;
   bit          m_ok = 1'b0, m_burn = 1'b0;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0000) return 16'h1234;
      return a ^ 16'hC3C3;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_update();
      if (!reset) begin
         m_pc = 16'h0000; m_ir = 16'h0000; m_irpc = 16'h0000; m_p2 = 16'h0002;
         m_v = 1'b0; m_mis = 1'b0; m_ok = 1'b0; m_burn = 1'b0;
      end else if (redirect_valid) begin
         m_v = 1'b0; m_ok = 1'b0; m_burn = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         if (redirect_pc[0]) m_mis = 1'b1;
         else                m_pc  = redirect_pc;
`else
         m_pc = redirect_pc & 16'hFFFE;
`endif
      end else if (m_v) begin
         if (ir_ready) m_v = 1'b0;
      end else if (stall) begin
         if (m_ok) begin
            m_ok = 1'b0;
            m_burn = 1'b1;
         end
      end else if (m_burn) begin
         m_burn = 1'b0;
      end else if (m_ok) begin
         m_ir   = mem_word(m_pc);
         m_irpc = m_pc;
         m_pc   = m_pc + 16'd2;
         m_p2   = m_pc;
         m_v    = 1'b1;
         m_ok   = 1'b0;
      end else begin
         m_ok = 1'b1;
      end
   endtask

   // One clock: memory responds, fetch_active checked, edge, registered outputs checked.
   task automatic step();
      logic exp_fa;
      #1;
      if (stall) mem_out = 16'hDEAD ^ 16'(cyc);
      else if (fetch_active) mem_out = mem_word(pc_out);
      exp_fa = reset && !m_v && !m_ok && !m_burn && !stall;
      chk("fetch_active", {15'd0, fetch_active}, {15'd0, exp_fa});
      @(posedge clock);
      model_update();
      cyc++;
      @(negedge clock);
      chk("pc_out",       pc_out,   m_pc);
      chk("ir",           ir,       m_ir);
      chk("ir_valid",     {15'd0, ir_valid}, {15'd0, m_v});
      chk("ir_pc",        ir_pc,    m_irpc);
      chk("pc_plus2",     pc_plus2, m_p2);
      chk("misalign_err", {15'd0, misalign_err}, {15'd0, m_mis});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; stall = 1'b0; mem_out = 16'h0000;
      redirect_valid = 1'b0; redirect_pc = 16'h0000; ir_ready = 1'b1;
      @(negedge clock);
      step(); step();
      chk("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
      chk("rst_pc_out",   pc_out,   16'h0000);
      chk("rst_pc_plus2", pc_plus2, 16'h0002);
      chk("rst_ir",       ir,       16'h0000);

      // First fetch after release, ir_ready held high.
      reset = 1'b1;
      step();
      chk("lat1_ir_valid", {15'd0, ir_valid}, 16'd0);
      step();
      chk("lat2_ir_valid", {15'd0, ir_valid}, 16'd1);
      chk("first_ir",      ir,       16'h1234);
      chk("first_ir_pc",   ir_pc,    16'h0000);
      chk("first_plus2",   pc_plus2, 16'h0002);
      chk("first_pc_out",  pc_out,   16'h0002);

      // Hold with ir_ready low for 5 cycles.
      ir_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_fa",    {15'd0, fetch_active}, 16'd0);
         chk("hold_ir",    ir,     16'h1234);
         chk("hold_pc",    pc_out, 16'h0002);
         chk("hold_valid", {15'd0, ir_valid}, 16'd1);
      end
      ir_ready = 1'b1;
      step();
      chk("consume_valid", {15'd0, ir_valid}, 16'd0);
      ir_ready = 1'b0;
      step(); step();
      chk("second_ir",    ir,     16'hC3C1);
      chk("second_ir_pc", ir_pc,  16'h0002);
      chk("second_pc",    pc_out, 16'h0004);

      // Stall for 3 cycles while in CAPT.
      ir_ready = 1'b1; step();
      ir_ready = 1'b0; step();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_ir", ir, 16'hC3C1);
         chk("stall_fa", {15'd0, fetch_active}, 16'd0);
      end
      stall = 1'b0;
      step(); step();
      chk("stall_rec_valid", {15'd0, ir_valid}, 16'd0);
      step();
      chk("stall_ir_new", ir,    16'hC3C7);
      chk("stall_ir_pc",  ir_pc, 16'h0004);

      // Redirect on the CAPT edge squashes the capture.
      ir_ready = 1'b1; step();
      ir_ready = 1'b0; step();
      redirect_valid = 1'b1; redirect_pc = 16'h0040;
      step();
      redirect_valid = 1'b0;
      chk("redir_ir_kept", ir,     16'hC3C7);
      chk("redir_pc",      pc_out, 16'h0040);
      step(); step();
      chk("redir_ir",    ir,       16'hC383);
      chk("redir_ir_pc", ir_pc,    16'h0040);
      chk("redir_plus2", pc_plus2, 16'h0042);

      // Redirect beats simultaneous ir_ready and stall; then wrap at 16'hFFFE.
      redirect_valid = 1'b1; redirect_pc = 16'hFFFE; ir_ready = 1'b1; stall = 1'b1;
      step();
      redirect_valid = 1'b0; ir_ready = 1'b0; stall = 1'b0;
      chk("prio_pc",    pc_out, 16'hFFFE);
      chk("prio_valid", {15'd0, ir_valid}, 16'd0);
      step(); step();
      chk("wrap_ir_pc", ir_pc,    16'hFFFE);
      chk("wrap_plus2", pc_plus2, 16'h0000);
      chk("wrap_pc",    pc_out,   16'h0000);
      chk("wrap_ir",    ir,       16'h3C3D);

      // Odd redirect target.
      redirect_valid = 1'b1; redirect_pc = 16'h0043;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("odd_pc",  pc_out, 16'h0000);
      chk("odd_mis", {15'd0, misalign_err}, 16'd1);
`else
      chk("odd_pc",  pc_out, 16'h0042);
      chk("odd_mis", {15'd0, misalign_err}, 16'd0);
`endif
      step(); step();
`ifdef FETCH_ALIGN_CHECK_EN
      chk("odd_ir_pc",  ir_pc, 16'h0000);
      chk("odd_mis_st", {15'd0, misalign_err}, 16'd1);
`else
      chk("odd_ir_pc",  ir_pc, 16'h0042);
      chk("odd_ir",     ir,    16'hC381);
`endif

      // Reset in the middle of a fetch (CAPT).
      ir_ready = 1'b1; step();
      ir_ready = 1'b0; step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mid_rst_valid", {15'd0, ir_valid}, 16'd0);
      chk("mid_rst_pc",    pc_out, 16'h0000);
      chk("mid_rst_ir",    ir,     16'h0000);
      chk("mid_rst_mis",   {15'd0, misalign_err}, 16'd0);
      step(); step();
      chk("post_rst_ir",    ir, 16'h1234);
      chk("post_rst_valid", {15'd0, ir_valid}, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
